// File: rtl/psk_pkg.sv
// Shared types and amplitude helpers for the BPSK/QPSK modulator.
package psk_pkg;

   typedef enum logic {
      MODE_BPSK = 1'b0,
      MODE_QPSK = 1'b1
   } mode_e;

   typedef struct packed {
      logic i_bit;
      logic q_bit;
   } sym_t;

   function automatic int amp_f(input int dw);
      return (1 << (dw - 1)) - 1;
   endfunction

   // round(amp/sqrt2) in fixed point: 46341/65536 ~= 1/sqrt2
   function automatic int amp_q_f(input int dw);
      longint a;
      a = longint'(amp_f(dw));
      return int'((a * 64'sd46341 + 64'sd32768) >>> 16);
   endfunction

endpackage

// File: rtl/psk_symbol_mapper.sv
// Combinational symbol-to-constellation mapper (BPSK on I only, QPSK on both axes).
module psk_symbol_mapper
   import psk_pkg::*;
#(
   parameter int DATA_W = 13,
   parameter int AMP    = amp_f(DATA_W),
   parameter int AMP_Q  = amp_q_f(DATA_W)
) (
   input  sym_t              sym_i,
   input  mode_e             mode_i,
   output logic [DATA_W-1:0] i_o,
   output logic [DATA_W-1:0] q_o
);

   function automatic logic signed [DATA_W-1:0] map_axis(input logic b, input int mag);
      logic signed [DATA_W-1:0] m;
      m = DATA_W'(mag);
      return b ? m : -m;
   endfunction

   always_comb begin
      i_o = '0;
      q_o = '0;
      if (mode_i == MODE_QPSK) begin
         i_o = map_axis(sym_i.i_bit, AMP_Q);
         q_o = map_axis(sym_i.q_bit, AMP_Q);
      end else begin
         i_o = map_axis(sym_i.i_bit, AMP);
      end
   end

endmodule

// File: rtl/psk_modulator.sv
// BPSK/QPSK baseband modulator with differential BPSK and a one-symbol prefetch buffer.
module psk_modulator
   import psk_pkg::*;
#(
   parameter int DATA_W = 13,
   parameter int CNT_W  = 32,
   parameter int AMP    = amp_f(DATA_W),
   parameter int AMP_Q  = amp_q_f(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mode_i,
   input  logic              diff_en_i,
   input  logic [CNT_W-1:0]  cycles_per_sym_i,
   input  logic              bit_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] i_data_o,
   output logic [DATA_W-1:0] q_data_o,
   output logic              valid_o,
   output logic              underrun_o
);

   sym_t             cur_q, cur_d, pend_q, pend_d, new_sym;
   logic             cur_vld_q, cur_vld_d, pend_vld_q, pend_vld_d;
   logic             half_q, half_d, half_vld_q, half_vld_d;
   logic             prev_tx_q, prev_tx_d, underrun_q, underrun_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d, n_eff;
   mode_e            mode_q, mode_d, eff_mode;
   logic             idle, acc, last, sym_done, tx_bit;
   logic [DATA_W-1:0] map_i, map_q;

   // Mode only follows mode_i while nothing is in flight, so a symbol never mixes modes
   assign idle     = !cur_vld_q && !pend_vld_q && !half_vld_q;
   assign eff_mode = idle ? mode_e'(mode_i) : mode_q;
   assign ready_o  = !pend_vld_q;
   assign acc      = valid_i && ready_o;
   assign n_eff    = (cycles_per_sym_i == '0) ? CNT_W'(1) : cycles_per_sym_i;
   assign last     = cur_vld_q && (cnt_q == n_q - CNT_W'(1));
   assign tx_bit   = bit_i ^ (diff_en_i & prev_tx_q);

   always_comb begin
      new_sym  = '0;
      sym_done = 1'b0;
      if (eff_mode == MODE_QPSK) begin
         sym_done      = acc && half_vld_q;
         new_sym.i_bit = half_q;
         new_sym.q_bit = bit_i;
      end else begin
         sym_done      = acc;
         new_sym.i_bit = tx_bit;
      end
   end

   always_comb begin
      cur_d      = cur_q;
      cur_vld_d  = cur_vld_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      half_d     = half_q;
      half_vld_d = half_vld_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      prev_tx_d  = prev_tx_q;
      underrun_d = 1'b0;
      mode_d     = eff_mode;

      if (acc && eff_mode == MODE_QPSK) begin
         half_vld_d = !half_vld_q;
         if (!half_vld_q) half_d = bit_i;
      end
      if (sym_done && eff_mode == MODE_BPSK) prev_tx_d = tx_bit;

      if (!cur_vld_q) begin
         if (sym_done) begin
            cur_d     = new_sym;
            cur_vld_d = 1'b1;
            cnt_d     = '0;
            n_d       = n_eff;
         end
      end else if (last) begin
         // Pending symbol has priority; a bit arriving now can only load if nothing is pending
         if (pend_vld_q) begin
            cur_d      = pend_q;
            pend_vld_d = 1'b0;
            cnt_d      = '0;
            n_d        = n_eff;
         end else if (sym_done) begin
            cur_d = new_sym;
            cnt_d = '0;
            n_d   = n_eff;
         end else begin
            cur_vld_d  = 1'b0;
            underrun_d = half_vld_d;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         if (sym_done) begin
            pend_d     = new_sym;
            pend_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur_vld_q  <= 1'b0;
         pend_vld_q <= 1'b0;
         half_vld_q <= 1'b0;
         cnt_q      <= '0;
         prev_tx_q  <= 1'b0;
         underrun_q <= 1'b0;
         mode_q     <= MODE_BPSK;
      end else begin
         cur_vld_q  <= cur_vld_d;
         pend_vld_q <= pend_vld_d;
         half_vld_q <= half_vld_d;
         cnt_q      <= cnt_d;
         prev_tx_q  <= prev_tx_d;
         underrun_q <= underrun_d;
         mode_q     <= mode_d;
      end
   end

   // Payload registers are qualified by their valid flags and need no reset
   always_ff @(posedge clk_i) begin
      cur_q  <= cur_d;
      pend_q <= pend_d;
      half_q <= half_d;
      n_q    <= n_d;
   end

   psk_symbol_mapper #(
      .DATA_W (DATA_W),
      .AMP    (AMP),
      .AMP_Q  (AMP_Q)
   ) u_mapper (
      .sym_i  (cur_q),
      .mode_i (mode_q),
      .i_o    (map_i),
      .q_o    (map_q)
   );

   assign i_data_o   = cur_vld_q ? map_i : '0;
   assign q_data_o   = cur_vld_q ? map_q : '0;
   assign valid_o    = cur_vld_q;
   assign underrun_o = underrun_q;

endmodule

// File: tb/tb_psk_modulator.sv
// Directed bench for psk_modulator: per-cycle vector table plus stream and corner sequences.
module tb_psk_modulator;

   localparam int A  = 4095;
   localparam int AQ = 2896;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        mode_i = 1'b0;
   logic        diff_en_i = 1'b0;
   logic [31:0] cycles_per_sym_i = 32'd1;
   logic        bit_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [12:0] i_data_o;
   logic [12:0] q_data_o;
   logic        valid_o;
   logic        underrun_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic        mode;
      logic        diff;
      logic [31:0] n;
      logic        vin;
      logic        b;
      logic        evo;
      logic        erdy;
      int          ei;
      int          eq;
      logic        eur;
   } vec_t;

   vec_t tbl[$];
   int   sbits[16];

   psk_modulator dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .mode_i           (mode_i),
      .diff_en_i        (diff_en_i),
      .cycles_per_sym_i (cycles_per_sym_i),
      .bit_i            (bit_i),
      .valid_i          (valid_i),
      .ready_o          (ready_o),
      .i_data_o         (i_data_o),
      .q_data_o         (q_data_o),
      .valid_o          (valid_o),
      .underrun_o       (underrun_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required<1000000", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int si(input logic [12:0] v);
      return int'($signed(v));
   endfunction

   function automatic vec_t mk(input logic rst, input logic mode, input logic diff,
                               input logic [31:0] n, input logic vin, input logic b,
                               input logic evo, input int ei, input int eq);
      vec_t v;
      v.rst = rst; v.mode = mode; v.diff = diff; v.n = n; v.vin = vin; v.b = b;
      v.evo = evo; v.erdy = 1'b1; v.ei = ei; v.eq = eq; v.eur = 1'b0;
      return v;
   endfunction

   // Streams sbits[0:nb-1] with handshake; expected outputs come from the symbol index
   task automatic run_stream(input string nm, input logic qp, input int n, input int nb);
      int k, nsym, first, tc, s, ei, eq;
      logic evo, rdy_pre;
      mode_i = qp; diff_en_i = 1'b0; cycles_per_sym_i = 32'(n);
      k = 0;
      nsym  = qp ? nb / 2 : nb;
      first = qp ? 1 : 0;
      tc    = first + nsym * n + 2;
      for (int e = 0; e < tc; e++) begin
         valid_i = (k < nb);
         bit_i   = (k < nb) ? sbits[k][0] : 1'b0;
         rdy_pre = ready_o;
         step();
         if (valid_i && rdy_pre) k++;
         evo = 1'b0; ei = 0; eq = 0;
         if (e >= first && e < first + nsym * n) begin
            s   = (e - first) / n;
            evo = 1'b1;
            if (qp) begin
               ei = sbits[2*s]   ? AQ : -AQ;
               eq = sbits[2*s+1] ? AQ : -AQ;
            end else begin
               ei = sbits[s] ? A : -A;
            end
         end
         chk({nm, "_valid"}, int'(valid_o), int'(evo));
         chk({nm, "_i"}, si(i_data_o), ei);
         chk({nm, "_q"}, si(q_data_o), eq);
         if (!qp)
            chk({nm, "_ready"}, int'(ready_o), int'((e % n == 0) || (e >= (nsym - 1) * n)));
      end
      chk({nm, "_accepted"}, k, nb);
      valid_i = 1'b0;
   endtask

   initial begin
      int b14[14];
      b14 = '{1,0,0,0,1,1,1,1,1,0,1,0,0,1};

      // Reset, BPSK N=1 continuous stream
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 14; i++)
         tbl.push_back(mk(0, 0, 0, 1, 1, b14[i][0], 1, b14[i] ? A : -A, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      // Differential BPSK: bits 1,1,0,1 -> tx 1,0,0,1
      tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1,  A, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, -A, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, -A, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1,  A, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
      // cycles_per_sym = 0 behaves as 1
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1,  A, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, -A, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1,  A, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[r]) begin
         rst_i = tbl[r].rst; mode_i = tbl[r].mode; diff_en_i = tbl[r].diff;
         cycles_per_sym_i = tbl[r].n; valid_i = tbl[r].vin; bit_i = tbl[r].b;
         step();
         chk($sformatf("tbl%0d_valid", r), int'(valid_o), int'(tbl[r].evo));
         chk($sformatf("tbl%0d_ready", r), int'(ready_o), int'(tbl[r].erdy));
         chk($sformatf("tbl%0d_i", r), si(i_data_o), tbl[r].ei);
         chk($sformatf("tbl%0d_q", r), si(q_data_o), tbl[r].eq);
         chk($sformatf("tbl%0d_underrun", r), int'(underrun_o), int'(tbl[r].eur));
      end
      rst_i = 1'b0; valid_i = 1'b0;

      // BPSK N=6 back-to-back through the prefetch buffer
      for (int i = 0; i < 14; i++) sbits[i] = b14[i];
      run_stream("bpsk_n6", 1'b0, 6, 14);

      // QPSK N=4: 11 01 00 10
      sbits[0] = 1; sbits[1] = 1; sbits[2] = 0; sbits[3] = 1;
      sbits[4] = 0; sbits[5] = 0; sbits[6] = 1; sbits[7] = 0;
      run_stream("qpsk_n4", 1'b1, 4, 8);

      // QPSK starvation with a held half symbol, then deferred mode change
      rst_i = 1'b1; step(); rst_i = 1'b0;
      mode_i = 1'b1; cycles_per_sym_i = 32'd2;
      valid_i = 1'b1; bit_i = 1'b1; step();
      chk("starve_first_half_valid", int'(valid_o), 0);
      bit_i = 1'b0; step();
      chk("starve_sym_valid", int'(valid_o), 1);
      chk("starve_sym_i", si(i_data_o), AQ);
      chk("starve_sym_q", si(q_data_o), -AQ);
      bit_i = 1'b1; step();
      chk("starve_hold_i", si(i_data_o), AQ);
      chk("starve_hold_ur", int'(underrun_o), 0);
      valid_i = 1'b0; step();
      chk("starve_idle_valid", int'(valid_o), 0);
      chk("starve_idle_i", si(i_data_o), 0);
      chk("starve_underrun_pulse", int'(underrun_o), 1);
      step();
      chk("starve_underrun_single", int'(underrun_o), 0);
      mode_i = 1'b0; step(); step();
      chk("starve_still_idle", int'(valid_o), 0);
      valid_i = 1'b1; bit_i = 1'b1; step();
      chk("resume_valid", int'(valid_o), 1);
      chk("resume_i", si(i_data_o), AQ);
      chk("resume_q", si(q_data_o), AQ);
      valid_i = 1'b0; step();
      chk("resume_hold", int'(valid_o), 1);
      step();
      chk("resume_end_valid", int'(valid_o), 0);
      chk("resume_end_ur", int'(underrun_o), 0);
      valid_i = 1'b1; bit_i = 1'b1; step();
      chk("mode_now_bpsk_i", si(i_data_o), A);
      chk("mode_now_bpsk_q", si(q_data_o), 0);
      valid_i = 1'b0; step(); step();

      // Reset in the middle of a BPSK N=6 symbol with a pending symbol queued
      mode_i = 1'b0; cycles_per_sym_i = 32'd6;
      valid_i = 1'b1; bit_i = 1'b1; step();
      bit_i = 1'b0; step();
      valid_i = 1'b0; step();
      chk("mid_valid", int'(valid_o), 1);
      chk("mid_i", si(i_data_o), A);
      chk("mid_ready_pend_full", int'(ready_o), 0);
      rst_i = 1'b1; step();
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_i", si(i_data_o), 0);
      chk("rst_q", si(q_data_o), 0);
      chk("rst_ready", int'(ready_o), 1);
      chk("rst_ur", int'(underrun_o), 0);
      rst_i = 1'b0; step();
      chk("post_rst_pend_cleared", int'(valid_o), 0);
      step();
      chk("post_rst_still_idle", int'(valid_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
